// File: rtl/hadamard_pkg.sv
// rtl/hadamard_pkg.sv - shared types and constants for the hadamard unit
package hadamard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ACK
    } state_t;

    typedef enum logic [1:0] {
        FP_NORMAL,
        FP_ZERO,
        FP_INF,
        FP_NAN
    } fp_class_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_W    = 8;
    localparam int          MANT_W   = 23;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam int          MUL_LAT  = 3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ACK   = 1;
    localparam int STAT_DONE  = 0;
    localparam int STAT_ACKED = 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    // Denormals count as zero: the multiplier flushes them on input.
    function automatic fp_class_t classify(input fp32_t f);
        if (f.exp == '0)
            return FP_ZERO;
        else if (f.exp == '1)
            return (f.mant == '0) ? FP_INF : FP_NAN;
        else
            return FP_NORMAL;
    endfunction

endpackage

// File: rtl/fp32_mul.sv
// rtl/fp32_mul.sv - three-stage pipelined FP32 multiplier, round-to-nearest-even, FTZ
module fp32_mul
    import hadamard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result
);

    fp32_t     fa, fb;
    fp_class_t ca, cb, c_in;
    logic [47:0] ma_ext, mb_ext;

    assign fa     = a;
    assign fb     = b;
    assign ca     = classify(fa);
    assign cb     = classify(fb);
    assign ma_ext = {24'b0, 1'b1, fa.mant};
    assign mb_ext = {24'b0, 1'b1, fb.mant};

    always_comb begin
        c_in = FP_NORMAL;
        if (ca == FP_NAN || cb == FP_NAN ||
            (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF))
            c_in = FP_NAN;
        else if (ca == FP_INF || cb == FP_INF)
            c_in = FP_INF;
        else if (ca == FP_ZERO || cb == FP_ZERO)
            c_in = FP_ZERO;
    end

    logic               s1_valid, s1_sign;
    fp_class_t          s1_class;
    logic [47:0]        s1_prod;
    logic signed [10:0] s1_exp;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_class <= FP_ZERO;
            s1_prod  <= '0;
            s1_exp   <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_sign  <= fa.sign ^ fb.sign;
            s1_class <= c_in;
            s1_prod  <= ma_ext * mb_ext;
            s1_exp   <= $signed({3'b0, fa.exp}) + $signed({3'b0, fb.exp}) - 11'sd127;
        end
    end

    // The product of two [1,2) mantissas lies in [1,4): at most one normalising shift.
    logic               norm, guard, sticky, round_up;
    logic [22:0]        mant_t;
    logic [23:0]        mant_r;
    logic signed [10:0] exp_n;

    always_comb begin
        norm     = s1_prod[47];
        mant_t   = norm ? s1_prod[46:24] : s1_prod[45:23];
        guard    = norm ? s1_prod[23] : s1_prod[22];
        sticky   = norm ? (|s1_prod[22:0]) : (|s1_prod[21:0]);
        round_up = guard & (sticky | mant_t[0]);
        mant_r   = {1'b0, mant_t} + {23'b0, round_up};
        exp_n    = s1_exp + $signed({10'b0, norm}) + $signed({10'b0, mant_r[23]});
    end

    logic               s2_valid, s2_sign;
    fp_class_t          s2_class;
    logic [22:0]        s2_mant;
    logic signed [10:0] s2_exp;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_class <= FP_ZERO;
            s2_mant  <= '0;
            s2_exp   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_class <= s1_class;
            s2_mant  <= mant_r[22:0];
            s2_exp   <= exp_n;
        end
    end

    logic [31:0] packed_res;

    always_comb begin
        packed_res = {s2_sign, 31'b0};
        case (s2_class)
            FP_NAN:  packed_res = QNAN;
            FP_INF:  packed_res = {s2_sign, 8'hFF, 23'b0};
            FP_ZERO: packed_res = {s2_sign, 31'b0};
            default: begin
                if (s2_exp >= 11'sd255)
                    packed_res = {s2_sign, 8'hFF, 23'b0};
                else if (s2_exp <= 11'sd0)
                    packed_res = {s2_sign, 31'b0};
                else
                    packed_res = {s2_sign, s2_exp[7:0], s2_mant};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= s2_valid;
            result    <= packed_res;
        end
    end

endmodule

// File: rtl/hadamard_unit.sv
// rtl/hadamard_unit.sv - streams A[i]*B[i] from two BRAMs into a product BRAM
module hadamard_unit
    import hadamard_pkg::*;
#(
    parameter int BRAM_WIDTH = 32,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           ps_control,
    output logic [31:0]           pl_status,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    output logic [ADDR_WIDTH-1:0] bram_addr_product,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_a,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_b,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_product,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_a,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_b,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_product,
    output logic [WORD_BYTES-1:0] bram_we_a,
    output logic [WORD_BYTES-1:0] bram_we_b,
    output logic [WORD_BYTES-1:0] bram_we_product,
    output logic                  mult_out_valid
);

    localparam int N     = (2 ** ADDR_WIDTH) / WORD_BYTES;
    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t                  state;
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic                    rd_issue, rd_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_ab;
    logic [1:0]              status;
    logic                    mul_valid;
    logic [31:0]             mul_result;

    logic unused_inputs;
    assign unused_inputs = ^{bram_rddata_product, ps_control[31:2]};

    assign bram_addr_a   = addr_ab;
    assign bram_addr_b   = addr_ab;
    assign bram_wrdata_a = '0;
    assign bram_wrdata_b = '0;
    assign bram_we_a     = '0;
    assign bram_we_b     = '0;
    assign pl_status     = {30'b0, status};
    assign mult_out_valid = mul_valid;

    // Read data for an address issued in cycle t appears in cycle t+1, so the tag lags by one.
    fp32_mul u_mul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_valid_d),
        .a         (bram_rddata_a[31:0]),
        .b         (bram_rddata_b[31:0]),
        .out_valid (mul_valid),
        .result    (mul_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            rd_idx              <= '0;
            wr_idx              <= '0;
            rd_issue            <= 1'b0;
            rd_valid_d          <= 1'b0;
            addr_ab             <= '0;
            bram_addr_product   <= '0;
            bram_wrdata_product <= '0;
            bram_we_product     <= '0;
            status              <= 2'b00;
        end else begin
            bram_we_product <= '0;
            rd_valid_d      <= rd_issue;
            case (state)
                ST_IDLE: begin
                    status <= 2'b00;
                    if (ps_control[CTRL_START]) begin
                        state    <= ST_RUN;
                        rd_idx   <= '0;
                        wr_idx   <= '0;
                        addr_ab  <= '0;
                        rd_issue <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rd_issue) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_issue <= 1'b0;
                        end else begin
                            rd_idx  <= rd_idx + IDX_W'(1);
                            addr_ab <= {rd_idx + IDX_W'(1), {OFF_W{1'b0}}};
                        end
                    end
                    if (mul_valid) begin
                        bram_we_product     <= '1;
                        bram_wrdata_product <= BRAM_WIDTH'(mul_result);
                        bram_addr_product   <= {wr_idx, {OFF_W{1'b0}}};
                        wr_idx              <= wr_idx + IDX_W'(1);
                        if (wr_idx == LAST_IDX)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ps_control[CTRL_ACK]) begin
                        state  <= ST_ACK;
                        status <= 2'b11;
                    end else begin
                        status <= 2'b01;
                    end
                end
                default: begin
                    if (ps_control[1:0] == 2'b00) begin
                        state  <= ST_IDLE;
                        status <= 2'b00;
                    end else begin
                        status <= 2'b11;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hadamard_unit.sv
// tb/tb_hadamard_unit.sv - directed self-checking bench for hadamard_unit
module tb_hadamard_unit;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ps_control;
    logic [31:0] pl_status;
    logic [11:0] addr_a, addr_b, addr_p;
    logic [31:0] rd_a, rd_b, rd_p;
    logic [31:0] wd_a, wd_b, wd_p;
    logic [3:0]  we_a, we_b, we_p;
    logic        mult_out_valid;

    always #5 clk = ~clk;

    hadamard_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .ps_control          (ps_control),
        .pl_status           (pl_status),
        .bram_addr_a         (addr_a),
        .bram_addr_b         (addr_b),
        .bram_addr_product   (addr_p),
        .bram_rddata_a       (rd_a),
        .bram_rddata_b       (rd_b),
        .bram_rddata_product (rd_p),
        .bram_wrdata_a       (wd_a),
        .bram_wrdata_b       (wd_b),
        .bram_wrdata_product (wd_p),
        .bram_we_a           (we_a),
        .bram_we_b           (we_b),
        .bram_we_product     (we_p),
        .mult_out_valid      (mult_out_valid)
    );

    logic [31:0] mem_a [N];
    logic [31:0] mem_b [N];
    logic [31:0] mem_p [N];
    logic [31:0] exp_p [N];
    int          wcnt  [N];
    logic        mon_clear;
    int          order_err, we_bad, wr_total;
    int          ab_we_err = 0;
    logic [11:0] exp_waddr;
    int          tests_run = 0;
    int          tests_failed = 0;

    always @(posedge clk) begin
        rd_a <= mem_a[addr_a[11:2]];
        rd_b <= mem_b[addr_b[11:2]];
        rd_p <= mem_p[addr_p[11:2]];
    end

    always @(posedge clk) begin
        if (we_a != 4'h0 || we_b != 4'h0)
            ab_we_err <= ab_we_err + 1;
        if (mon_clear) begin
            order_err <= 0;
            we_bad    <= 0;
            wr_total  <= 0;
            exp_waddr <= 12'h0;
            for (int i = 0; i < N; i++) begin
                wcnt[i]  <= 0;
                mem_p[i] <= 32'hDEADBEEF;
            end
        end else if (we_p != 4'h0) begin
            if (we_p != 4'hF) we_bad <= we_bad + 1;
            if (addr_p != exp_waddr) order_err <= order_err + 1;
            exp_waddr <= exp_waddr + 12'd4;
            wr_total  <= wr_total + 1;
            wcnt[addr_p[11:2]]  <= wcnt[addr_p[11:2]] + 1;
            mem_p[addr_p[11:2]] <= wd_p;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        mon_clear = 1'b1;
        tick();
        mon_clear = 1'b0;
    endtask

    task automatic load_uniform(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = a;
            mem_b[i] = b;
            exp_p[i] = e;
        end
    endtask

    task automatic set_pair(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        mem_a[idx] = a;
        mem_b[idx] = b;
        exp_p[idx] = e;
    endtask

    task automatic wait_status(input logic [1:0] mask, input logic [1:0] val, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if ((pl_status[1:0] & mask) == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int count_bad_words();
        int n = 0;
        for (int i = 0; i < N; i++)
            if (mem_p[i] !== exp_p[i]) n++;
        return n;
    endfunction

    function automatic int count_bad_writes();
        int n = 0;
        for (int i = 0; i < N; i++)
            if (wcnt[i] != 1) n++;
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        ps_control = 32'h0;
        mon_clear = 1'b1;
        repeat (3) tick();
        mon_clear = 1'b0;
        tests_run++;
        if (pl_status !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h expected 00000000", pl_status); end
        tests_run++;
        if (addr_a !== 12'h0 || addr_b !== 12'h0 || addr_p !== 12'h0) begin
            tests_failed++; $display("FAIL reset_addr: got a=%h b=%h p=%h expected 000", addr_a, addr_b, addr_p);
        end
        tests_run++;
        if (we_p !== 4'h0 || we_a !== 4'h0 || we_b !== 4'h0) begin
            tests_failed++; $display("FAIL reset_we: got a=%h b=%h p=%h expected 0", we_a, we_b, we_p);
        end
        tests_run++;
        if (wd_p !== 32'h0 || wd_a !== 32'h0 || wd_b !== 32'h0) begin
            tests_failed++; $display("FAIL reset_wrdata: got a=%h b=%h p=%h expected 0", wd_a, wd_b, wd_p);
        end
        tests_run++;
        if (mult_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mult_valid: got %b expected 0", mult_out_valid); end
        reset = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (pl_status !== 32'h0 || we_p !== 4'h0) begin
            tests_failed++; $display("FAIL idle_quiet: got status=%h we=%h expected 0/0", pl_status, we_p);
        end
    endtask

    task automatic test_run_basic();
        bit ok;
        load_uniform(32'hC0000000, 32'h418C0000, 32'hC20C0000);
        clear_monitor();
        ps_control = 32'h1;
        tick();
        tick();
        ps_control = 32'h3;
        wait_status(2'b11, 2'b11, 2000, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL basic_timeout: status=%h expected 3 within 2000 cycles", pl_status); end
        tests_run++;
        if (pl_status !== 32'h3) begin tests_failed++; $display("FAIL basic_status: got %h expected 00000003", pl_status); end
        tests_run++;
        if (count_bad_words() != 0) begin tests_failed++; $display("FAIL basic_products: %0d bad words, word0=%h expected c20c0000", count_bad_words(), mem_p[0]); end
        tests_run++;
        if (wr_total != N || order_err != 0 || we_bad != 0 || count_bad_writes() != 0) begin
            tests_failed++;
            $display("FAIL basic_writes: total=%0d order_err=%0d we_bad=%0d dup=%0d expected %0d/0/0/0",
                     wr_total, order_err, we_bad, count_bad_writes(), N);
        end
        ps_control = 32'h0;
        wait_status(2'b11, 2'b00, 2, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL basic_clear: status=%h expected 0 within 2 cycles", pl_status); end
    endtask

    task automatic test_handshake();
        bit ok;
        int dev;
        int total_before;
        load_uniform(32'hC0490FDB, 32'h402DF854, 32'hC108A2C0);
        clear_monitor();
        ps_control = 32'h1;
        wait_status(2'b01, 2'b01, 2000, ok);
        tests_run++;
        if (!ok || pl_status !== 32'h1) begin tests_failed++; $display("FAIL hs_done: ok=%0d status=%h expected 00000001", ok, pl_status); end
        dev = 0;
        repeat (4) begin
            tick();
            if (pl_status !== 32'h1) dev++;
        end
        tests_run++;
        if (dev != 0) begin tests_failed++; $display("FAIL hs_no_early_ack: %0d cycles deviated, expected status 00000001", dev); end
        ps_control = 32'h2;
        wait_status(2'b11, 2'b11, 2, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL hs_ack: status=%h expected 3 within 2 cycles", pl_status); end
        tests_run++;
        if (count_bad_words() != 0) begin tests_failed++; $display("FAIL pie_products: %0d bad words, word0=%h expected c108a2c0", count_bad_words(), mem_p[0]); end
        total_before = wr_total;
        ps_control = 32'h1;
        dev = 0;
        repeat (6) begin
            tick();
            if (pl_status !== 32'h3 || mult_out_valid !== 1'b0 || addr_a !== 12'hFFC) dev++;
        end
        tests_run++;
        if (dev != 0 || wr_total != total_before) begin
            tests_failed++; $display("FAIL hs_hold_no_rerun: dev=%0d writes=%0d expected 0/%0d", dev, wr_total, total_before);
        end
        ps_control = 32'h0;
        wait_status(2'b11, 2'b00, 2, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL hs_clear: status=%h expected 0 within 2 cycles", pl_status); end
    endtask

    task automatic load_specials();
        for (int i = 0; i < N; i++)
            set_pair(i, 32'h3F800000, 32'h40000000 | (i << 3), 32'h40000000 | (i << 3));
        set_pair(0,  32'h00000000, 32'h3F800000, 32'h00000000);
        set_pair(1,  32'h80000000, 32'h3F800000, 32'h80000000);
        set_pair(2,  32'h00000000, 32'hBF800000, 32'h80000000);
        set_pair(3,  32'h7F800000, 32'h3F800000, 32'h7F800000);
        set_pair(4,  32'h7F800000, 32'h00000000, 32'h7FC00000);
        set_pair(5,  32'h7F000000, 32'h7F000000, 32'h7F800000);
        set_pair(6,  32'hFF800000, 32'h3F800000, 32'hFF800000);
        set_pair(7,  32'h7F800001, 32'h3F800000, 32'h7FC00000);
        set_pair(8,  32'h00000001, 32'h3F800000, 32'h00000000);
        set_pair(9,  32'h00800000, 32'h00800000, 32'h00000000);
        set_pair(10, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
        set_pair(11, 32'h3F800001, 32'h3FC00000, 32'h3FC00002);
        set_pair(12, 32'h3F800003, 32'h3FC00000, 32'h3FC00004);
        set_pair(13, 32'h3FFFFFFF, 32'h3F800001, 32'h40000000);
        set_pair(14, 32'h7F800000, 32'hC0000000, 32'hFF800000);
        set_pair(15, 32'h00000000, 32'h7F800000, 32'h7FC00000);
        set_pair(16, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
        set_pair(17, 32'h80000000, 32'h80000000, 32'h00000000);
    endtask

    task automatic test_reset_mid_run();
        load_specials();
        clear_monitor();
        ps_control = 32'h1;
        repeat (200) tick();
        tests_run++;
        if (mult_out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrun_active: mult_out_valid=%b expected 1", mult_out_valid); end
        reset = 1'b1;
        ps_control = 32'h0;
        tick();
        tests_run++;
        if (pl_status !== 32'h0 || we_p !== 4'h0 || mult_out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midrun_reset: status=%h we=%h mov=%b expected 0/0/0", pl_status, we_p, mult_out_valid);
        end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_special_values();
        bit ok;
        int bad_rest;
        clear_monitor();
        ps_control = 32'h1;
        wait_status(2'b01, 2'b01, 2000, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL special_timeout: status=%h expected done within 2000 cycles", pl_status); end
        for (int i = 0; i < 18; i++) begin
            tests_run++;
            if (mem_p[i] !== exp_p[i]) begin
                tests_failed++;
                $display("FAIL special_%0d: %h * %h got %h expected %h", i, mem_a[i], mem_b[i], mem_p[i], exp_p[i]);
            end
        end
        bad_rest = count_bad_words();
        tests_run++;
        if (bad_rest != 0) begin tests_failed++; $display("FAIL special_indexed: %0d bad words, word1023=%h expected %h", bad_rest, mem_p[1023], exp_p[1023]); end
        tests_run++;
        if (wr_total != N || order_err != 0 || we_bad != 0 || count_bad_writes() != 0) begin
            tests_failed++;
            $display("FAIL special_writes: total=%0d order_err=%0d we_bad=%0d dup=%0d expected %0d/0/0/0",
                     wr_total, order_err, we_bad, count_bad_writes(), N);
        end
        ps_control = 32'h2;
        wait_status(2'b11, 2'b11, 2, ok);
        ps_control = 32'h0;
        wait_status(2'b11, 2'b00, 2, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL special_clear: status=%h expected 0", pl_status); end
        tests_run++;
        if (ab_we_err != 0) begin tests_failed++; $display("FAIL ab_we: %0d cycles with A/B we set, expected 0", ab_we_err); end
    endtask

    initial begin
        mon_clear  = 1'b0;
        reset      = 1'b1;
        ps_control = 32'h0;
        test_reset();
        test_run_basic();
        test_handshake();
        test_reset_mid_run();
        test_special_values();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
